// File: rtl/tt_sweep_ctrl_if.sv
// tt_sweep_ctrl_if: signal bundle between a truth-table sweep controller and
// its host plus the 3-input circuit-under-test.
//   slave  : the sweep controller itself (accepts start/abort, drives the CUT)
//   master : the host requesting sweeps, together with the CUT output
interface tt_sweep_ctrl_if;
    logic       start;
    logic       abort;
    logic       dut_in1;
    logic       dut_in2;
    logic       dut_in3;
    logic       dut_out;
    logic       busy;
    logic       done;
    logic [7:0] truth_table;
    logic [7:0] mismatch_mask;
    logic       pass;
    logic [7:0] unstable_mask;

    modport slave (
        input  start,
        input  abort,
        input  dut_out,
        output dut_in1,
        output dut_in2,
        output dut_in3,
        output busy,
        output done,
        output truth_table,
        output mismatch_mask,
        output pass,
        output unstable_mask
    );

    modport master (
        output start,
        output abort,
        output dut_out,
        input  dut_in1,
        input  dut_in2,
        input  dut_in3,
        input  busy,
        input  done,
        input  truth_table,
        input  mismatch_mask,
        input  pass,
        input  unstable_mask
    );
endinterface

// File: rtl/tt_sweep_ctrl.sv
// tt_sweep_ctrl: walks a 3-input combinational circuit through its 8 input
// rows, holds each row SETTLE_CYC cycles, samples the output at the end of
// each row and commits the observed truth-table hex together with a
// comparison against EXPECTED.
// Row r drives {dut_in1,dut_in2,dut_in3} = r and its sample lands in bit 7-r.
// Optional feature: define TT_STABILITY_CHECK_EN to take an extra sample one
// cycle before the final one and flag rows whose output still moved
// (requires SETTLE_CYC >= 2). Without it unstable_mask is constant zero.
module tt_sweep_ctrl #(
    parameter int unsigned SETTLE_CYC = 4,
    parameter logic [7:0]  EXPECTED   = 8'h46
) (
    input logic            clk,
    input logic            rst_n,
    tt_sweep_ctrl_if.slave sweep_if
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Counter value at which the final sample of a row is taken.
    localparam logic [7:0] LAST_CNT  = 8'(SETTLE_CYC - 32'd1);
`ifdef TT_STABILITY_CHECK_EN
    // Counter value at which the early (stability) sample is taken.
    localparam logic [7:0] EARLY_CNT = 8'(SETTLE_CYC - 32'd2);
`endif

    state_e     state_q, state_d;
    logic [2:0] row_q, row_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] shadow_q, shadow_d;
`ifdef TT_STABILITY_CHECK_EN
    logic [7:0] ushadow_q, ushadow_d;
    logic       early_q, early_d;
    logic [7:0] unstable_q, unstable_d;
`endif

    logic [2:0] dut_in_q, dut_in_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [7:0] tt_q, tt_d;
    logic [7:0] mm_q, mm_d;
    logic       pass_q, pass_d;

    logic       sample_s;
    logic       abort_s;
    logic       commit_s;

    // Decode the per-cycle events that steer the sequencer.
    always_comb begin
        sample_s = 1'b0;
        abort_s  = 1'b0;
        if (state_q == ST_RUN) begin
            sample_s = (cnt_q == LAST_CNT);
            abort_s  = sweep_if.abort;
        end else begin
            sample_s = 1'b0;
            abort_s  = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: abort beats the last sample, DONE always lasts one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (sweep_if.start) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort_s) begin
                    state_d = ST_IDLE;
                end else if (sample_s && (row_q == 3'd7)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Row/settle counter and shadow truth table for the sweep in progress.
    always_comb begin
        row_d    = row_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
`ifdef TT_STABILITY_CHECK_EN
        ushadow_d = ushadow_q;
        early_d   = early_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (sweep_if.start) begin
                    row_d    = 3'd0;
                    cnt_d    = 8'd0;
                    shadow_d = 8'h00;
`ifdef TT_STABILITY_CHECK_EN
                    ushadow_d = 8'h00;
                    early_d   = 1'b0;
`endif
                end else begin
                    row_d = row_q;
                end
            end
            ST_RUN: begin
                if (abort_s) begin
                    // Partial sweep is discarded; the next start reinitialises.
                    row_d = row_q;
                end else if (sample_s) begin
                    cnt_d                     = 8'd0;
                    row_d                     = row_q + 3'd1;
                    shadow_d[3'd7 - row_q]    = sweep_if.dut_out;
`ifdef TT_STABILITY_CHECK_EN
                    if (sweep_if.dut_out != early_q) begin
                        ushadow_d[3'd7 - row_q] = 1'b1;
                    end else begin
                        ushadow_d[3'd7 - row_q] = ushadow_q[3'd7 - row_q];
                    end
`endif
                end else begin
                    cnt_d = cnt_q + 8'd1;
`ifdef TT_STABILITY_CHECK_EN
                    if (cnt_q == EARLY_CNT) begin
                        early_d = sweep_if.dut_out;
                    end else begin
                        early_d = early_q;
                    end
`endif
                end
            end
            ST_DONE: begin
                row_d = row_q;
            end
            default: begin
                row_d = 3'd0;
                cnt_d = 8'd0;
            end
        endcase
    end

    // Sweep datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q    <= 3'd0;
            cnt_q    <= 8'd0;
            shadow_q <= 8'h00;
`ifdef TT_STABILITY_CHECK_EN
            ushadow_q <= 8'h00;
            early_q   <= 1'b0;
`endif
        end else begin
            row_q    <= row_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
`ifdef TT_STABILITY_CHECK_EN
            ushadow_q <= ushadow_d;
            early_q   <= early_d;
`endif
        end
    end

    // Output decode: outputs are registered from the next state so busy,
    // dut_in and the committed result line up with the state they belong to.
    always_comb begin
        commit_s = (state_q == ST_RUN) && (state_d == ST_DONE);
        busy_d   = (state_d == ST_RUN);
        done_d   = (state_d == ST_DONE);
        if (state_d == ST_RUN) begin
            dut_in_d = row_d;
        end else begin
            dut_in_d = 3'd0;
        end
        if (commit_s) begin
            tt_d = shadow_d;
            mm_d = shadow_d ^ EXPECTED;
`ifdef TT_STABILITY_CHECK_EN
            unstable_d = ushadow_d;
            pass_d     = ((shadow_d ^ EXPECTED) == 8'h00) && (ushadow_d == 8'h00);
`else
            pass_d     = ((shadow_d ^ EXPECTED) == 8'h00);
`endif
        end else begin
            tt_d   = tt_q;
            mm_d   = mm_q;
            pass_d = pass_q;
`ifdef TT_STABILITY_CHECK_EN
            unstable_d = unstable_q;
`endif
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dut_in_q <= 3'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            tt_q     <= 8'h00;
            mm_q     <= 8'h00;
            pass_q   <= 1'b0;
`ifdef TT_STABILITY_CHECK_EN
            unstable_q <= 8'h00;
`endif
        end else begin
            dut_in_q <= dut_in_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            tt_q     <= tt_d;
            mm_q     <= mm_d;
            pass_q   <= pass_d;
`ifdef TT_STABILITY_CHECK_EN
            unstable_q <= unstable_d;
`endif
        end
    end

    assign sweep_if.dut_in1       = dut_in_q[2];
    assign sweep_if.dut_in2       = dut_in_q[1];
    assign sweep_if.dut_in3       = dut_in_q[0];
    assign sweep_if.busy          = busy_q;
    assign sweep_if.done          = done_q;
    assign sweep_if.truth_table   = tt_q;
    assign sweep_if.mismatch_mask = mm_q;
    assign sweep_if.pass          = pass_q;
`ifdef TT_STABILITY_CHECK_EN
    assign sweep_if.unstable_mask = unstable_q;
`else
    assign sweep_if.unstable_mask = 8'h00;
`endif

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// tb_tt_sweep_ctrl: two controller instances (long and short settle time)
// driving a behavioural 3-input circuit; directed plus randomized sweeps
// checked against a cycle-indexed reference of the sweep protocol.
module tb_tt_sweep_ctrl;

    localparam int S_A = 4;
`ifdef TT_STABILITY_CHECK_EN
    localparam int S_B = 2;
`else
    localparam int S_B = 1;
`endif
    localparam logic [7:0] EXP_HEX = 8'h46;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tt_sweep_ctrl_if if_a ();
    tt_sweep_ctrl_if if_b ();

    tt_sweep_ctrl #(.SETTLE_CYC(S_A), .EXPECTED(EXP_HEX)) u_a (
        .clk(clk), .rst_n(rst_n), .sweep_if(if_a.slave));
    tt_sweep_ctrl #(.SETTLE_CYC(S_B), .EXPECTED(EXP_HEX)) u_b (
        .clk(clk), .rst_n(rst_n), .sweep_if(if_b.slave));

    // Behavioural circuit: truth table ct, optional stuck output, optional glitch.
    logic [7:0] ct = 8'h46;
    logic       stuck_en = 1'b0;
    logic       stuck_val = 1'b0;
    logic       glitch_on = 1'b0;
    int         glitch_row_g = -1;
    wire [2:0]  row_a = {if_a.dut_in1, if_a.dut_in2, if_a.dut_in3};
    wire [2:0]  row_b = {if_b.dut_in1, if_b.dut_in2, if_b.dut_in3};
    assign if_a.dut_out = (stuck_en ? stuck_val : ct[3'd7 - row_a]) ^ (glitch_on && (32'(row_a) == glitch_row_g));
    assign if_b.dut_out = (stuck_en ? stuck_val : ct[3'd7 - row_b]) ^ (glitch_on && (32'(row_b) == glitch_row_g));

    // Reference copy of committed results per instance.
    logic [7:0] m_tt [2];
    logic [7:0] m_mm [2];
    logic [7:0] m_un [2];
    logic       m_pass [2];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [2:0] get_in(input int s);
        return (s == 0) ? row_a : row_b;
    endfunction
    function automatic logic get_busy(input int s);
        return (s == 0) ? if_a.busy : if_b.busy;
    endfunction
    function automatic logic get_done(input int s);
        return (s == 0) ? if_a.done : if_b.done;
    endfunction

    task automatic set_start(input int s, input logic v);
        if (s == 0) if_a.start = v; else if_b.start = v;
    endtask
    task automatic set_abort(input int s, input logic v);
        if (s == 0) if_a.abort = v; else if_b.abort = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_commit(input int s, input string tag);
        if (s == 0) begin
            check_val({tag, "_tt"},   if_a.truth_table,   m_tt[0]);
            check_val({tag, "_mm"},   if_a.mismatch_mask, m_mm[0]);
            check_val({tag, "_un"},   if_a.unstable_mask, m_un[0]);
            check_val({tag, "_pass"}, if_a.pass,          m_pass[0]);
        end else begin
            check_val({tag, "_tt"},   if_b.truth_table,   m_tt[1]);
            check_val({tag, "_mm"},   if_b.mismatch_mask, m_mm[1]);
            check_val({tag, "_un"},   if_b.unstable_mask, m_un[1]);
            check_val({tag, "_pass"}, if_b.pass,          m_pass[1]);
        end
    endtask

    // Compute the result a full sweep should commit, from the circuit setup.
    task automatic model_commit(input int s, input int S, input int grow);
        logic [7:0] t;
        logic [7:0] u;
        u = 8'h00;
        for (int r = 0; r < 8; r++) t[7-r] = stuck_en ? stuck_val : ct[7-r];
`ifdef TT_STABILITY_CHECK_EN
        if (grow >= 0 && S >= 2) u[7-grow] = 1'b1;
`endif
        m_tt[s]   = t;
        m_mm[s]   = t ^ EXP_HEX;
        m_un[s]   = u;
        m_pass[s] = ((t ^ EXP_HEX) == 8'h00) && (u == 8'h00);
    endtask

    // One sweep on instance s. abort_k>0 asserts abort in cycle k after start.
    task automatic run_sweep(input int s, input int abort_k, input int grow, input bit noise);
        int S;
        int total;
        S = (s == 0) ? S_A : S_B;
        total = 8 * S + 1;
        glitch_row_g = grow;
        set_start(s, 1'b1);
        tick();
        set_start(s, 1'b0);
        for (int k = 1; k <= total; k++) begin
            if (k < total) begin
                int r;
                int j;
                r = (k - 1) / S;
                j = (k - 1) % S;
                check_val("run_busy", get_busy(s), 1);
                check_val("run_din",  get_in(s), r);
                check_val("run_done", get_done(s), 0);
                glitch_on = (r == grow) && (j == S - 2);
                if (noise) set_start(s, 1'($urandom % 2));
                if (k == abort_k) begin
                    set_abort(s, 1'b1);
                    tick();
                    set_abort(s, 1'b0);
                    set_start(s, 1'b0);
                    glitch_on = 1'b0;
                    check_val("abort_busy", get_busy(s), 0);
                    check_val("abort_din",  get_in(s), 0);
                    check_val("abort_done", get_done(s), 0);
                    check_commit(s, "abort");
                    tick();
                    check_val("abort_idle_done", get_done(s), 0);
                    check_val("abort_idle_busy", get_busy(s), 0);
                    return;
                end
            end else begin
                glitch_on = 1'b0;
                model_commit(s, S, grow);
                check_val("done_pulse", get_done(s), 1);
                check_val("done_busy",  get_busy(s), 0);
                check_val("done_din",   get_in(s), 0);
                check_commit(s, "done");
                if (noise) set_start(s, 1'($urandom % 2));
            end
            tick();
        end
        set_start(s, 1'b0);
        check_val("post_done", get_done(s), 0);
        check_val("post_busy", get_busy(s), 0);
        check_commit(s, "post");
    endtask

    // start held high for two back-to-back sweeps.
    task automatic run_held(input int s);
        int S;
        int P;
        S = (s == 0) ? S_A : S_B;
        P = 8 * S + 2;
        glitch_row_g = -1;
        set_start(s, 1'b1);
        tick();
        for (int k = 1; k <= 2 * P; k++) begin
            int p;
            p = (k - 1) % P;
            check_val("held_busy", get_busy(s), (p < 8 * S) ? 1 : 0);
            check_val("held_din",  get_in(s), (p < 8 * S) ? p / S : 0);
            check_val("held_done", get_done(s), (p == 8 * S) ? 1 : 0);
            if (p == 8 * S) begin
                model_commit(s, S, -1);
                check_commit(s, "held");
            end
            if (k == 2 * P) set_start(s, 1'b0);
            tick();
        end
        check_val("held_stop_busy", get_busy(s), 0);
    endtask

    task automatic reset_checks(input string tag);
        for (int s = 0; s < 2; s++) begin
            check_val({tag, "_busy"}, get_busy(s), 0);
            check_val({tag, "_done"}, get_done(s), 0);
            check_val({tag, "_din"},  get_in(s), 0);
            check_commit(s, tag);
        end
    endtask

    task automatic clear_model();
        for (int s = 0; s < 2; s++) begin
            m_tt[s] = 8'h00; m_mm[s] = 8'h00; m_un[s] = 8'h00; m_pass[s] = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        if_a.start = 1'b0; if_a.abort = 1'b0;
        if_b.start = 1'b0; if_b.abort = 1'b0;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        reset_checks("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Correct circuit, long settle.
        ct = 8'h46; stuck_en = 1'b0;
        run_sweep(0, 0, -1, 1'b0);
        // Output stuck at 0.
        stuck_en = 1'b1; stuck_val = 1'b0;
        run_sweep(0, 0, -1, 1'b0);
        // Restore a passing result, then abort during row 3 with output stuck at 1.
        stuck_en = 1'b0;
        run_sweep(0, 0, -1, 1'b0);
        stuck_en = 1'b1; stuck_val = 1'b1;
        run_sweep(0, 3 * S_A + 2, -1, 1'b0);
        // Abort exactly at the final sample edge.
        run_sweep(0, 8 * S_A, -1, 1'b0);
        // Back-to-back sweeps with start held.
        stuck_en = 1'b0;
        run_held(0);
        // Short settle instance.
        run_sweep(1, 0, -1, 1'b0);
        // Row 2 changes between early and final sample.
        run_sweep(0, 0, 2, 1'b0);
        // Abort in IDLE does nothing.
        set_abort(0, 1'b1);
        tick();
        set_abort(0, 1'b0);
        check_val("idle_abort_busy", get_busy(0), 0);
        check_commit(0, "idle_abort");

        // Randomized sweeps.
        for (int it = 0; it < 40; it++) begin
            int s;
            int S;
            int ak;
            int gr;
            s = int'($urandom % 2);
            S = (s == 0) ? S_A : S_B;
            ct = 8'($urandom);
            if (it % 5 == 0) ct = EXP_HEX;
            stuck_en  = ($urandom % 5) == 0;
            stuck_val = 1'($urandom % 2);
            ak = (($urandom % 4) == 0) ? 1 + int'($urandom % (8 * S)) : 0;
            gr = (($urandom % 3) == 0) ? int'($urandom % 8) : -1;
            run_sweep(s, ak, gr, 1'b1);
        end

        // Reset in the middle of a sweep clears committed results.
        stuck_en = 1'b0; ct = 8'h46;
        run_sweep(1, 0, -1, 1'b0);
        set_start(0, 1'b1);
        tick();
        set_start(0, 1'b0);
        repeat (5 + ($urandom % 10)) tick();
        rst_n = 1'b0;
        #1;
        clear_model();
        reset_checks("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_sweep(0, 0, -1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tt_sweep_ctrl.md
Name: tt_sweep_ctrl

Overview:
Sequencer that drives a 3-input combinational gate-level circuit (e.g. the 0x46 NOR/NOT netlist) through all 8 input rows.
- Waits a programmable settle time per row, then samples the circuit output.
- Assembles the observed 8-bit truth-table hex and compares it against an expected value.
- Sits beside the circuit-under-test in score/regression benches and FPGA checkers; one instance per circuit.

Parameters:
SETTLE_CYC, 4, cycles each row is held before sampling (legal range 1..255).
EXPECTED, 8'h46, expected truth-table hex in Cello row ordering.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
start  input  1  sweep request; accepted only in IDLE
abort  input  1  cancel an in-progress sweep
dut_in1  output  1  drives circuit in1
dut_in2  output  1  drives circuit in2
dut_in3  output  1  drives circuit in3
dut_out  input  1  circuit output
busy  output  1  high from the cycle after start is accepted until the sweep ends
done  output  1  one-cycle pulse when results are committed
truth_table  output  8  last committed observed truth table
mismatch_mask  output  8  truth_table XOR EXPECTED, committed with truth_table
pass  output  1  committed result: mask==0 (and, with the option, unstable_mask==0)
unstable_mask  output  8  per-row instability flags; constant 0 when the option is absent

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE.
  - dut_in1/2/3=0, busy=0, done=0.
  - truth_table=0, mismatch_mask=0, pass=0, unstable_mask=0.
- Row encoding:
  - Row r (0..7) drives {dut_in1,dut_in2,dut_in3}=r[2:0], so dut_in1 is the MSB.
  - The sample of row r lands in bit [7-r]. Row 0 maps to the MSB of the hex.
- FSM states: IDLE, RUN, DONE.
  - IDLE: dut_in=0. When start=1 at an edge, go to RUN with row=0 and cnt=0. Next cycle busy=1 and dut_in=row 0.
  - RUN: cnt increments each cycle.
    - At the edge where cnt==SETTLE_CYC-1, dut_out is sampled into shadow bit [7-row], cnt resets to 0 and row increments.
    - When row==7 at that edge, go to DONE instead.
    - Each row is held exactly SETTLE_CYC cycles.
  - DONE: lasts one cycle.
    - done=1, busy=0, dut_in=0.
    - The shadow is copied to truth_table, and mismatch_mask and pass are updated on entry, so they are visible in the same cycle as done.
    - Always returns to IDLE.
- Latency: the start edge to the done-high cycle is 8*SETTLE_CYC+1 cycles.
- start while busy or in DONE: ignored and not queued. start held high re-triggers from IDLE on the following cycle.
- abort in RUN: next cycle IDLE, busy=0, dut_in=0, no done pulse, committed outputs unchanged. abort in IDLE or DONE has no effect.
- abort and the final sample on the same edge: abort wins and nothing is committed.
- Committed outputs are stable between done pulses.
- Reset mid-sweep clears everything, including committed results.
- SETTLE_CYC==1: the row advances every cycle and the sample is taken at the first edge after the row is applied.

Optional Feature:
Macro TT_STABILITY_CHECK_EN.
- Defined:
  - SETTLE_CYC must be >=2.
  - dut_out is additionally sampled at cnt==SETTLE_CYC-2. If it differs from the final sample, shadow unstable bit [7-row] is set.
  - unstable_mask is committed at DONE. pass = (mismatch_mask==0) && (unstable_mask==0).
- Undefined: no early sample is taken, unstable_mask is tied to 0, and pass depends on mismatch_mask only.

Test Plan:
1. Correct circuit, SETTLE_CYC=4: reset, pulse start. Expect done at cycle 33 after the start edge, truth_table=8'h46, mismatch_mask=0, pass=1, dut_in sequence 000..111 each held 4 cycles.
2. Stuck fault, dut_out tied to 0: expect truth_table=8'h00, mismatch_mask=8'h46, pass=0.
3. Abort mid-sweep: complete test 1, start again with dut_out=1, assert abort during row 3. Expect busy=0 next cycle, no done pulse, truth_table still 8'h46, pass still 1.
4. Start held high continuously: expect back-to-back sweeps with done every 34 cycles and busy low for 2 cycles between sweeps (DONE + IDLE).
5. SETTLE_CYC=1 with correct circuit: done 9 cycles after start, truth_table=8'h46.
6. Stability (macro defined), SETTLE_CYC=4: toggle dut_out between the early and final sample of row 2 only. Expect unstable_mask=8'h20 and pass=0 even with truth_table=8'h46.
